// File: rtl/qr_pkg.sv
// Shared fixed-point widths, FSM encoding and the output quantiser used by
// the inner-product, projection and back-substitution stages.
package qr_pkg;

  localparam int H_W    = 24;  // h sample, s1.22
  localparam int E_W    = 24;  // unit vector e, s7.16
  localparam int R_W    = 20;  // Rij component, s3.16
  localparam int PROD_W = 48;  // e*h product, s9.38
  localparam int ACC_W  = 50;  // accumulator, s11.38

  localparam int H_FRAC = 22;
  localparam int E_FRAC = 16;
  localparam int R_FRAC = 16;

  // Accumulator bit that lands on the output LSB, and the output MSB position.
  localparam int Q_SHIFT = H_FRAC + E_FRAC - R_FRAC;
  localparam int Q_MSB   = Q_SHIFT + R_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } ip_state_e;

  typedef struct packed {
    logic           sat;
    logic [R_W-1:0] val;
  } q_res_t;

  // Round (optional half-up) and saturate an s11.38 sum to s3.16. The
  // saturation test looks at every bit above the kept field: if they are
  // not all copies of the sign, the value does not fit.
  function automatic q_res_t quant_sat(input logic signed [ACC_W-1:0] acc,
                                       input logic                    rnd);
    logic [ACC_W-1:0] half;
    logic [ACC_W-1:0] r;
    q_res_t           q;
    half            = '0;
    half[Q_SHIFT-1] = rnd;
    r               = acc + half;
    q.sat = !((&r[ACC_W-1:Q_MSB]) || !(|r[ACC_W-1:Q_MSB]));
    if (q.sat)
      q.val = r[ACC_W-1] ? {1'b1, {(R_W-1){1'b0}}} : {1'b0, {(R_W-1){1'b1}}};
    else
      q.val = r[Q_MSB:Q_SHIFT];
    return q;
  endfunction

endpackage

// File: rtl/cmac_conj.sv
// Combinational conjugate complex multiply: conj(a + jb) * (hRe + j hIm).
module cmac_conj
  import qr_pkg::*;
(
  input  logic signed [E_W-1:0]    a,
  input  logic signed [E_W-1:0]    b,
  input  logic signed [H_W-1:0]    h_re,
  input  logic signed [H_W-1:0]    h_im,
  output logic signed [PROD_W-1:0] t_re,
  output logic signed [PROD_W-1:0] t_im
);

  logic signed [PROD_W-1:0] p_ar, p_bi, p_ai, p_br;

  // Operands are sign-extended to the product width before multiplying.
  assign p_ar = PROD_W'(a) * PROD_W'(h_re);
  assign p_bi = PROD_W'(b) * PROD_W'(h_im);
  assign p_ai = PROD_W'(a) * PROD_W'(h_im);
  assign p_br = PROD_W'(b) * PROD_W'(h_re);

  assign t_re = p_ar + p_bi;
  assign t_im = p_ai - p_br;

endmodule

// File: rtl/inner_product.sv
// Rij = sum_k conj(e_k) * h_k over N_ROW rows, one complex MAC per cycle,
// valid/ready on both sides. Result is quantised to s3.16 with saturation.
module inner_product
  import qr_pkg::*;
#(
  parameter int N_ROW    = 4,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2*N_ROW*H_W-1:0]   i_h,
  input  logic [2*N_ROW*E_W-1:0]   i_e,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2*R_W-1:0]         o_rij,
  output logic                     o_sat
);

  localparam int K_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;

  ip_state_e                    state;
  logic [K_W-1:0]               k;
  logic [2*N_ROW-1:0][H_W-1:0]  h_q;   // even index = Re, odd index = Im
  logic [2*N_ROW-1:0][E_W-1:0]  e_q;   // even index = a,  odd index = b
  logic signed [ACC_W-1:0]      acc_re, acc_im;
  logic signed [ACC_W-1:0]      sum_re, sum_im;
  logic signed [E_W-1:0]        a_k, b_k;
  logic signed [H_W-1:0]        hr_k, hi_k;
  logic signed [PROD_W-1:0]     t_re, t_im;
  q_res_t                       q_re, q_im;
  logic                         accept;
  logic                         last;

  // Ready is decoded from state; in OUT a new beat may enter as the result leaves.
  assign o_ready = (state == ST_IDLE) || ((state == ST_OUT) && i_ready);
  assign accept  = i_valid && o_ready;
  assign last    = (k == K_W'(N_ROW - 1));

  // Select row k operands for the single shared multiplier.
  always_comb begin
    a_k  = e_q[{k, 1'b0}];
    b_k  = e_q[{k, 1'b1}];
    hr_k = h_q[{k, 1'b0}];
    hi_k = h_q[{k, 1'b1}];
  end

  cmac_conj u_cmac (
    .a    (a_k),
    .b    (b_k),
    .h_re (hr_k),
    .h_im (hi_k),
    .t_re (t_re),
    .t_im (t_im)
  );

  // Final sum is formed combinationally so the last row needs no extra cycle.
  assign sum_re = acc_re + ACC_W'(t_re);
  assign sum_im = acc_im + ACC_W'(t_im);
  assign q_re   = quant_sat(sum_re, ROUND_EN);
  assign q_im   = quant_sat(sum_im, ROUND_EN);

  // Control FSM, operand capture, accumulation and registered result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      h_q     <= '0;
      e_q     <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      o_valid <= 1'b0;
      o_rij   <= '0;
      o_sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            h_q    <= i_h;
            e_q    <= i_e;
            acc_re <= '0;
            acc_im <= '0;
            k      <= '0;
            state  <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_re <= sum_re;
          acc_im <= sum_im;
          k      <= k + K_W'(1);
          if (last) begin
            o_rij   <= {q_im.val, q_re.val};
            o_sat   <= q_re.sat | q_im.sat;
            o_valid <= 1'b1;
            k       <= '0;
            state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              h_q    <= i_h;
              e_q    <= i_e;
              acc_re <= '0;
              acc_im <= '0;
              k      <= '0;
              state  <= ST_ACC;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_product.sv
// Bench for inner_product: two instances (rounding / truncating) share one
// stimulus stream; a queue-based scoreboard checks both against an
// arithmetic reference.
module tb_inner_product;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         i_ready;
  logic [191:0] i_h;
  logic [191:0] i_e;

  logic         r_ready, r_valid, r_sat;
  logic [39:0]  r_rij;
  logic         t_ready, t_valid, t_sat;
  logic [39:0]  t_rij;

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [39:0] r1;
    logic        s1;
    logic [39:0] r0;
    logic        s0;
  } exp_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  inner_product #(.N_ROW(4), .ROUND_EN(1'b1)) dut_r (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(r_ready),
    .i_h(i_h), .i_e(i_e), .o_valid(r_valid), .i_ready(i_ready),
    .o_rij(r_rij), .o_sat(r_sat)
  );

  inner_product #(.N_ROW(4), .ROUND_EN(1'b0)) dut_t (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(t_ready),
    .i_h(i_h), .i_e(i_e), .o_valid(t_valid), .i_ready(i_ready),
    .o_rij(t_rij), .o_sat(t_sat)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // s3.16 quantiser on an exact integer sum in units of 2^-38.
  function automatic logic [20:0] mq(input longint s, input bit rnd);
    longint v;
    logic [63:0] u;
    v = (s + (rnd ? 64'sd2097152 : 64'sd0)) >>> 22;
    if (v > 64'sd524287)  return {1'b1, 20'h7FFFF};
    if (v < -64'sd524288) return {1'b1, 20'h80000};
    u = v;
    return {1'b0, u[19:0]};
  endfunction

  function automatic exp_t model(input logic [191:0] h, input logic [191:0] e);
    longint sre, sim, hr, hi, ar, br;
    logic [20:0] cr, ci, tr, ti;
    exp_t x;
    sre = 0;
    sim = 0;
    for (int r = 0; r < 4; r++) begin
      hr = longint'($signed(h[48*r +: 24]));
      hi = longint'($signed(h[48*r+24 +: 24]));
      ar = longint'($signed(e[48*r +: 24]));
      br = longint'($signed(e[48*r+24 +: 24]));
      sre += ar*hr + br*hi;
      sim += ar*hi - br*hr;
    end
    cr = mq(sre, 1'b1); ci = mq(sim, 1'b1);
    tr = mq(sre, 1'b0); ti = mq(sim, 1'b0);
    x.r1 = {ci[19:0], cr[19:0]};
    x.s1 = cr[20] | ci[20];
    x.r0 = {ti[19:0], tr[19:0]};
    x.s0 = tr[20] | ti[20];
    return x;
  endfunction

  function automatic logic [191:0] row0(input logic [23:0] re, input logic [23:0] im);
    logic [191:0] v;
    v = '0;
    v[23:0]  = re;
    v[47:24] = im;
    return v;
  endfunction

  // Random words, shrunk by a random shift so both saturating and in-range sums occur.
  function automatic logic [191:0] rvec();
    logic [191:0]       v;
    logic signed [23:0] x;
    for (int i = 0; i < 8; i++) begin
      x = 24'($urandom);
      x = x >>> $urandom_range(0, 14);
      v[24*i +: 24] = x;
    end
    return v;
  endfunction

  // Present one transaction; returns 1 time unit after its accept edge.
  task automatic send(input logic [191:0] h, input logic [191:0] e, input bit rdy_now);
    int w;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_h     = h;
    i_e     = e;
    if (rdy_now) i_ready = 1'b1;
    #1;
    w = 0;
    while (!r_ready && w < 200) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    if (!r_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
      i_valid = 1'b0;
      return;
    end
    sb.push_back(model(h, e));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_h     = rvec();
    i_e     = rvec();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge i_clk);
      #1;
      n++;
    end while (!r_valid && n < 50);
  endtask

  // Random downstream backpressure.
  initial forever begin
    @(negedge i_clk);
    if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: a handshake completes on the next rising edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst_n && r_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          x = sb.pop_front();
          chk("rij_round", 64'(r_rij), 64'(x.r1));
          chk("sat_round", 64'(r_sat), 64'(x.s1));
          chk("rij_trunc", 64'(t_rij), 64'(x.r0));
          chk("sat_trunc", 64'(t_sat), 64'(x.s0));
          chk("valid_pair", 64'(t_valid), 64'(r_valid));
        end
      end
    end
  end

  initial begin
    logic [191:0] h, e;
    logic [39:0]  hold;
    int           n;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_h     = '0;
    i_e     = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(r_valid), 64'd0);
    chk("rst_rij",   64'(r_rij),   64'd0);
    chk("rst_sat",   64'(r_sat),   64'd0);
    chk("rst_ready", 64'(r_ready), 64'd1);
    chk("rst_ready_t", 64'(t_ready), 64'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic: 1.0 * 0.5 = 0.5
    send(row0(24'h200000, 24'h0), row0(24'h010000, 24'h0), 1'b0);
    wait_valid(n);
    chk("lat_basic", 64'(n), 64'd4);
    chk("basic_rij", 64'(r_rij), 64'h0000008000);
    chk("basic_sat", 64'(r_sat), 64'd0);

    // Conjugate: e = j, h = 0.5 -> -0.5j
    send(row0(24'h200000, 24'h0), row0(24'h0, 24'h010000), 1'b0);
    wait_valid(n);
    chk("conj_rij", 64'(r_rij), 64'hF800000000);

    // Saturation in both directions
    h = '0;
    e = '0;
    for (int r = 0; r < 4; r++) begin
      h[48*r +: 24]    = 24'h3FFFFF;
      e[48*r +: 24]    = 24'h7FFFFF;
      e[48*r+24 +: 24] = 24'h7FFFFF;
    end
    send(h, e, 1'b0);
    wait_valid(n);
    chk("sat_rij", 64'(r_rij), 64'h800007FFFF);
    chk("sat_flag", 64'(r_sat), 64'd1);

    // Exactly half an output LSB
    send(row0(24'h200000, 24'h0), row0(24'h000001, 24'h0), 1'b0);
    wait_valid(n);
    chk("round_up", 64'(r_rij), 64'h0000000001);
    chk("round_trunc", 64'(t_rij), 64'h0000000000);
    @(posedge i_clk);
    #1;

    // Backpressure for 3 cycles, then same-edge handoff
    i_ready = 1'b0;
    send(rvec(), rvec(), 1'b0);
    wait_valid(n);
    chk("lat_bp", 64'(n), 64'd4);
    hold = r_rij;
    repeat (3) begin
      @(negedge i_clk);
      #1;
      chk("bp_stable", 64'(r_rij), 64'(hold));
      chk("bp_ready",  64'(r_ready), 64'd0);
      chk("bp_valid",  64'(r_valid), 64'd1);
    end
    send(rvec(), rvec(), 1'b1);
    chk("b2b_clear", 64'(r_valid), 64'd0);
    wait_valid(n);
    chk("lat_b2b", 64'(n), 64'd4);
    @(posedge i_clk);
    #1;

    // Reset while accumulating at k=2
    send(rvec(), rvec(), 1'b0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(r_valid), 64'd0);
    chk("rstmid_ready", 64'(r_ready), 64'd1);
    void'(sb.pop_back());
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge i_clk);
      #1;
      if (r_valid) n++;
    end
    chk("rstmid_no_out", 64'(n), 64'd0);
    send(rvec(), rvec(), 1'b0);
    wait_valid(n);
    chk("lat_after_rst", 64'(n), 64'd4);

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      send(rvec(), rvec(), 1'b0);
    end
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    rand_rdy = 1'b0;
    i_ready  = 1'b1;
    chk("drain", 64'(sb.size()), 64'd0);

    repeat (2) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
